// File: rtl/fifo_frame_pkg.sv
// Shared types and constants for the FIFO frame writer.
package fifo_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    PAYLOAD,
    DROP,
    GAP
  } state_t;

  localparam logic [15:0] HDR_WORD_DEFAULT = 16'hA55A;
  localparam int unsigned GAP_CYCLES       = 2;
  localparam int unsigned SEQ_W            = 16;
  localparam int unsigned DROP_W           = 16;

endpackage

// File: rtl/fifo_frame_writer.sv
// Packs a sample stream into header/sequence/payload frames and writes them to
// an async FIFO, admitting a frame only when the whole frame is known to fit.
module fifo_frame_writer
  import fifo_frame_pkg::*;
#(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       WR_DEPTH_WIDTH = 9,
  parameter int unsigned       FRAME_LEN      = 64,
  parameter logic [DATA_W-1:0] HDR_WORD       = DATA_W'(HDR_WORD_DEFAULT)
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic                      en,
  input  logic                      s_valid,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      s_ready,
  input  logic                      wfull,
  input  logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      w_en,
  output logic [DATA_W-1:0]         w_data,
  output logic                      frame_done,
  output logic [DROP_W-1:0]         drop_cnt,
  output logic                      busy
);

  localparam int unsigned FREE_W = WR_DEPTH_WIDTH + 2;
  localparam int unsigned BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [FREE_W-1:0] DEPTH     = FREE_W'(2 ** WR_DEPTH_WIDTH);
  localparam logic [FREE_W-1:0] NEED      = FREE_W'(FRAME_LEN + 2);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_t              r_state;
  logic                r_w_en;
  logic [DATA_W-1:0]   r_w_data;
  logic                r_frame_done;
  logic                r_s_ready;
  logic                r_busy;
  logic [BEAT_W-1:0]   r_beat;
  logic [GAP_W-1:0]    r_gap;
  logic [SEQ_W-1:0]    r_seq;
  logic [DROP_W-1:0]   r_drop_cnt;

  logic [FREE_W-1:0]   w_free;
  logic                w_admit;
  logic                w_accept;
  logic                w_last;

  // Room check: the whole frame (header + sequence + payload) must fit.
  assign w_free   = DEPTH - FREE_W'(wr_water_level);
  assign w_admit  = (w_free >= NEED) && !wfull;
  assign w_accept = s_valid && r_s_ready;
  assign w_last   = (r_beat == LAST_BEAT);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state      <= IDLE;
      r_w_en       <= 1'b0;
      r_w_data     <= '0;
      r_frame_done <= 1'b0;
      r_s_ready    <= 1'b0;
      r_busy       <= 1'b0;
      r_beat       <= '0;
      r_gap        <= '0;
      r_seq        <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_w_en       <= 1'b0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (en && s_valid) begin
            r_busy <= 1'b1;
            r_beat <= '0;
            if (w_admit) begin
              r_state  <= HDR;
              r_w_en   <= 1'b1;
              r_w_data <= HDR_WORD;
            end else begin
              r_state   <= DROP;
              r_s_ready <= 1'b1;
            end
          end
        end
        HDR: begin
          r_state  <= SEQ;
          r_w_en   <= 1'b1;
          r_w_data <= DATA_W'(r_seq);
        end
        SEQ: begin
          r_state   <= PAYLOAD;
          r_s_ready <= 1'b1;
        end
        PAYLOAD: begin
          if (w_accept) begin
            r_w_en   <= 1'b1;
            r_w_data <= s_data;
            r_beat   <= r_beat + BEAT_W'(1);
            if (w_last) begin
              r_frame_done <= 1'b1;
              r_seq        <= r_seq + SEQ_W'(1);
              r_s_ready    <= 1'b0;
              r_gap        <= '0;
              r_state      <= GAP;
            end
          end
        end
        DROP: begin
          // Beats are swallowed so the producer stays frame-aligned.
          if (w_accept) begin
            r_beat <= r_beat + BEAT_W'(1);
            if (w_last) begin
              if (r_drop_cnt != {DROP_W{1'b1}}) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
              r_s_ready <= 1'b0;
              r_gap     <= '0;
              r_state   <= GAP;
            end
          end
        end
        GAP: begin
          r_gap <= r_gap + GAP_W'(1);
          if (r_gap == GAP_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign w_en       = r_w_en;
  assign w_data     = r_w_data;
  assign frame_done = r_frame_done;
  assign drop_cnt   = r_drop_cnt;
  assign busy       = r_busy;

endmodule
